bpuf_multibit_ctrl: RTL and testbench
=====================================

// Module: bpuf_multibit_ctrl
// PURPOSE
//   Parametrised multi-bit successor of the one-bit BPUF top: a bank of CELLS BPUF cells driven by a sequencer.
//   One start produces a RESP_BITS-wide response, one bit per challenge slice, via ring-reset/settle/sample per bit.
//   Sits between the challenge interface and the response consumer.
//   Uses a valid/ready response handshake; the BPUF cells are instantiated inside.
// PARAMETERS
//   CELLS         10  BPUF cells in the bank (= challenge slice width), >=1
//   RESP_BITS     8   response bits per request, >=1
//   RING_RST_CYC  4   cycles excite forced 0 before each evaluation, >=1
//   SETTLE_CYC    16  cycles challenge slice applied before sampling, >=3 (covers 2-flop sync)
// PORTS
//   clk         in   1                  system clock, also drives every BPUF cell
//   rst_n       in   1                  asynchronous active-low reset
//   start       in   1                  request; accepted only in IDLE
//   chal        in   CELLS*RESP_BITS    challenge; slice k = chal[k*CELLS +: CELLS]
//   busy        out  1                  high in any state other than IDLE
//   resp_valid  out  1                  response available (DONE state)
//   resp_ready  in   1                  consumer accepts response
//   resp        out  RESP_BITS          response; bit k from slice k
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; busy=0, resp_valid=0, resp=0, excite bus=0, counters/bit index=0, sync flops=0.
//   Reset mid-operation aborts immediately: no resp_valid, and the latched challenge is discarded.
//   Cell outputs Q[CELLS-1:0] pass through a 2-flop synchroniser; sample value = ^Q_sync.
//   FSM:
//     IDLE   : excite=0. start=1 -> latch chal, k=0, clear resp -> RRST.
//     RRST   : excite=0 for RING_RST_CYC cycles -> APPLY.
//     APPLY  : excite=slice k for SETTLE_CYC cycles -> SAMPLE.
//     SAMPLE : 1 cycle; excite holds slice k; resp[k] <= sample.
//              If k==RESP_BITS-1 -> DONE, else k<=k+1 -> RRST.
//     DONE   : excite=0; resp_valid=1 and resp held stable.
//              resp_valid & resp_ready -> IDLE (resp_valid low next cycle, resp retained).
//   Latency (no vote): resp_valid rises RESP_BITS*(RING_RST_CYC+SETTLE_CYC+1)+1 cycles after the start cycle.
//   start while busy (including DONE) is ignored; no queueing. chal changes after acceptance have no effect.
//   resp_ready outside DONE is ignored. start and resp_ready together in DONE: handshake completes and start is dropped.
//   Counter widths: $clog2 of the larger of RING_RST_CYC and SETTLE_CYC, plus 1; bit index width $clog2(RESP_BITS)+1.
//   Cycle counters wrap only by FSM reload.
// CONFIGURATION
//   BPUF_MAJ_VOTE_EN defined:
//     - Each bit is evaluated 3 times (RRST->APPLY->SAMPLE x3); resp[k] = majority of the 3 samples.
//     - Per-bit time is 3*(RING_RST_CYC+SETTLE_CYC+1); latency scales to match.
//     - Adds vote_cnt[1:0] and a 2-bit ones counter.
//   BPUF_MAJ_VOTE_EN not defined: single sample per bit, no vote logic synthesised.
// TESTING (bench model: Q_i = excite_i delayed 1 cycle; CELLS=4, RESP_BITS=4, RING_RST_CYC=2, SETTLE_CYC=4)
//   1. Reset, then start pulse with chal=16'h1357 -> busy=1 the next cycle; resp_valid at cycle 29 after start; resp=4'b1001.
//   2. In DONE, hold resp_ready=0 for 10 cycles -> resp_valid and resp stay stable.
//      Then resp_ready=1 for 1 cycle -> IDLE, busy=0.
//   3. start=1 with chal=16'hFFFF at cycle 5 of an active run -> ignored; the original response is returned.
//   4. rst_n=0 mid-APPLY of bit 2 -> excite=0, busy=0, resp=0 immediately.
//      A new start after release gives the full latency of 29.
//   5. chal=16'h0000 -> resp=4'b0000. chal=16'h8421 -> resp=4'b1111.
//   6. With BPUF_MAJ_VOTE_EN, model flips Q on the 2nd evaluation of every bit, chal=16'h1357:
//      resp=4'b1001; resp_valid at cycle 85.

Source files
------------

// File: rtl/bpuf_multibit_ctrl.sv
// Multi-bit BPUF sequencer: ring-reset / settle / sample per challenge slice over a bank of cells.
// Optional BPUF_MAJ_VOTE_EN: each bit is evaluated three times and resolved by majority.
module bpuf_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic excite,
    output logic q
);
    logic q_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= 1'b0;
        else        q_q <= excite;
    end
    assign q = q_q;
endmodule

module bpuf_multibit_ctrl #(
    parameter int CELLS        = 10,
    parameter int RESP_BITS    = 8,
    parameter int RING_RST_CYC = 4,
    parameter int SETTLE_CYC   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CELLS*RESP_BITS-1:0] chal,
    output logic                       busy,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [RESP_BITS-1:0]       resp
);
    localparam int CW = $clog2((RING_RST_CYC > SETTLE_CYC) ? RING_RST_CYC : SETTLE_CYC) + 1;
    localparam int KW = $clog2(RESP_BITS) + 1;

    typedef enum logic [2:0] {S_IDLE, S_RRST, S_APPLY, S_SAMPLE, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [RESP_BITS-1:0][CELLS-1:0] chal_q, chal_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [RESP_BITS-1:0]            resp_q, resp_d;
    logic                            busy_q, busy_d;
    logic                            resp_valid_q, resp_valid_d;
    logic [CELLS-1:0]                excite_q, excite_d;
    logic [CELLS-1:0]                cell_q, sync1_q, sync2_q;
    logic [CELLS-1:0]                slice;
    logic                            sample;
    logic                            bit_val;
    logic                            last_eval;
`ifdef BPUF_MAJ_VOTE_EN
    logic [1:0]                      vote_cnt_q, vote_cnt_d;
    logic [1:0]                      ones_q, ones_d;
`endif

    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        bpuf_cell u_cell (.clk(clk), .rst_n(rst_n), .excite(excite_q[i]), .q(cell_q[i]));
    end

    assign sample = ^sync2_q;

    always_comb begin
        slice = '0;
        for (int i = 0; i < RESP_BITS; i++)
            if (k_q == KW'(i)) slice = chal_q[i];
    end

`ifdef BPUF_MAJ_VOTE_EN
    assign last_eval = (vote_cnt_q == 2'd2);
    assign bit_val   = ones_q[1] | (ones_q[0] & sample);
`else
    assign last_eval = 1'b1;
    assign bit_val   = sample;
`endif

    always_comb begin
        state_d      = state_q;
        chal_d       = chal_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        resp_d       = resp_q;
        busy_d       = busy_q;
        resp_valid_d = resp_valid_q;
        excite_d     = excite_q;
`ifdef BPUF_MAJ_VOTE_EN
        vote_cnt_d   = vote_cnt_q;
        ones_d       = ones_q;
`endif
        case (state_q)
            S_IDLE: begin
                excite_d = '0;
                if (start) begin
                    chal_d  = chal;
                    k_d     = '0;
                    resp_d  = '0;
                    cnt_d   = CW'(RING_RST_CYC - 1);
                    busy_d  = 1'b1;
                    state_d = S_RRST;
                end
            end
            S_RRST: begin
                if (cnt_q == '0) begin
                    cnt_d    = CW'(SETTLE_CYC - 1);
                    excite_d = slice;
                    state_d  = S_APPLY;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_APPLY: begin
                if (cnt_q == '0) state_d = S_SAMPLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_SAMPLE: begin
                excite_d = '0;
                cnt_d    = CW'(RING_RST_CYC - 1);
                state_d  = S_RRST;
`ifdef BPUF_MAJ_VOTE_EN
                vote_cnt_d = last_eval ? 2'd0 : vote_cnt_q + 2'd1;
                ones_d     = last_eval ? 2'd0 : ones_q + {1'b0, sample};
`endif
                if (last_eval) begin
                    for (int i = 0; i < RESP_BITS; i++)
                        if (k_q == KW'(i)) resp_d[i] = bit_val;
                    if (k_q == KW'(RESP_BITS - 1)) begin
                        resp_valid_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_DONE: begin
                excite_d = '0;
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            chal_q       <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            resp_q       <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            excite_q     <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
`ifdef BPUF_MAJ_VOTE_EN
            vote_cnt_q   <= '0;
            ones_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            chal_q       <= chal_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            resp_q       <= resp_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            excite_q     <= excite_d;
            sync1_q      <= cell_q;
            sync2_q      <= sync1_q;
`ifdef BPUF_MAJ_VOTE_EN
            vote_cnt_q   <= vote_cnt_d;
            ones_q       <= ones_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp       = resp_q;
endmodule

// File: tb/tb_bpuf_multibit_ctrl.sv
// Directed bench for bpuf_multibit_ctrl: cells echo excite one cycle later, so each bit is slice parity.
module tb_bpuf_multibit_ctrl;
    localparam int CELLS = 4, RB = 4, RR = 2, ST = 4;
`ifdef BPUF_MAJ_VOTE_EN
    localparam int LAT = RB * 3 * (RR + ST + 1) + 1;
`else
    localparam int LAT = RB * (RR + ST + 1) + 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CELLS*RB-1:0] chal = '0;
    logic              busy, resp_valid;
    logic              resp_ready = 1'b0;
    logic [RB-1:0]     resp;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] chal;
        logic [3:0]  resp;
    } vec_t;
    vec_t vt[6];

    bpuf_multibit_ctrl #(.CELLS(CELLS), .RESP_BITS(RB), .RING_RST_CYC(RR), .SETTLE_CYC(ST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chal(chal), .busy(busy),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle; on return we are in cycle 1 after the start cycle.
    task automatic do_start(input logic [15:0] c);
        chal  = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int n0, output int lat);
        lat = n0;
        while (!resp_valid && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake(input logic [3:0] exp_resp);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_valid", 32'(resp_valid), 32'd0);
        chk("hs_resp_kept", 32'(resp), 32'(exp_resp));
    endtask

    initial begin
        int lat;
        vt[0] = '{16'h1357, 4'b1001};
        vt[1] = '{16'h0000, 4'b0000};
        vt[2] = '{16'h8421, 4'b1111};
        vt[3] = '{16'hFFFF, 4'b0000};
        vt[4] = '{16'h2480, 4'b1110};
        vt[5] = '{16'h0001, 4'b0001};

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp", 32'(resp), 32'd0);
        chk("rst_excite", 32'(dut.excite_q), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_start(vt[i].chal);
            chk("busy_after_start", 32'(busy), 32'd1);
            wait_valid(1, lat);
            chk("latency", 32'(lat), 32'(LAT));
            chk("resp", 32'(resp), 32'(vt[i].resp));
            handshake(vt[i].resp);
            tick();
        end

        // Hold off the consumer in DONE, then accept with a concurrent start that must be dropped.
        do_start(16'h1357);
        wait_valid(1, lat);
        resp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("done_hold", {30'd0, resp_valid, busy}, 32'd3);
            chk("done_resp", 32'(resp), 32'h9);
        end
        start = 1'b1;
        chal  = 16'hFFFF;
        handshake(4'b1001);
        start = 1'b0;
        tick();
        chk("start_dropped", 32'(busy), 32'd0);

        // start while busy is ignored, and chal changes after acceptance have no effect.
        do_start(16'h1357);
        repeat (4) tick();
        chal  = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_ign", 32'(busy), 32'd1);
        wait_valid(6, lat);
        chk("ign_latency", 32'(lat), 32'(LAT));
        chk("ign_resp", 32'(resp), 32'h9);
        handshake(4'b1001);

        // Reset during APPLY of bit 2 aborts the run.
        tick();
        do_start(16'h1357);
        repeat (17) tick();
`ifndef BPUF_MAJ_VOTE_EN
        chk("partial_resp", 32'(resp), 32'h1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp", 32'(resp), 32'd0);
        chk("abort_excite", 32'(dut.excite_q), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(16'h8421);
        wait_valid(1, lat);
        chk("post_rst_latency", 32'(lat), 32'(LAT));
        chk("post_rst_resp", 32'(resp), 32'hF);
        handshake(4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
